branch_resolve_unit: RTL and testbench

- Execute-side counterpart to the fetch-side perceptron predictor.
- Holds a FIFO of in-flight branch checkpoints pushed at fetch: PC, predicted direction, predicted target, speculative GHR snapshot.
- At resolution it pops the oldest checkpoint and compares it against the actual outcome. It then drives the mispredict flush, the redirect PC, the restored GHR and a training strobe back to the predictor.

---
 rtl/branch_resolve_unit.sv | 219 +++++++++++++++++++++
 tb/tb_branch_resolve_unit.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_unit.sv
// -----------------------------------------------------------------------------
// branch_resolve_unit
//
// Execute-side partner of the fetch-side perceptron predictor. Fetch pushes a
// checkpoint for every predicted branch: PC, predicted direction, predicted
// target and the speculative GHR. Execute resolves the oldest branch. The head
// checkpoint is then compared with the real outcome, and the unit returns the
// following to the predictor one cycle later:
//   - a training strobe,
//   - a mispredict flush pulse,
//   - the corrected fetch PC,
//   - the repaired GHR.
//
// Optional feature: define BRU_STATS_EN to add the saturating counters
// stat_resolved_o and stat_mispredict_o.
//
// Ports:
//   clk_i, reset_i          clock (rising edge); async active-high reset
//   push_i, push_*_i        checkpoint capture from fetch
//   resolve_i, resolve_*_i  actual outcome of the oldest in-flight branch
//   full_o, empty_o,
//   count_o                 checkpoint FIFO occupancy
//   mispredict_o,
//   redirect_pc_o,
//   restore_ghr_o           flush pulse and recovery state
//   train_*_o               training strobe and payload for the predictor
//   err_overflow_o,
//   err_underflow_o         sticky protocol errors, cleared only by reset
//   stat_*_o                (BRU_STATS_EN only) resolve and mispredict counters
// -----------------------------------------------------------------------------
module branch_resolve_unit #(
  parameter int PC_WIDTH   = 32,
  parameter int HISTORY    = 16,
  parameter int DEPTH      = 4,
  parameter int DEPTH_ADDR = $clog2(DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  push_i,
  input  logic [PC_WIDTH-1:0]   push_pc_i,
  input  logic                  push_pred_i,
  input  logic [PC_WIDTH-1:0]   push_target_i,
  input  logic [HISTORY-1:0]    push_ghr_i,
  input  logic                  resolve_i,
  input  logic                  resolve_taken_i,
  input  logic [PC_WIDTH-1:0]   resolve_target_i,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [DEPTH_ADDR:0]   count_o,
  output logic                  mispredict_o,
  output logic [PC_WIDTH-1:0]   redirect_pc_o,
  output logic [HISTORY-1:0]    restore_ghr_o,
  output logic                  train_valid_o,
  output logic [PC_WIDTH-1:0]   train_pc_o,
  output logic                  train_taken_o,
  output logic                  train_pred_o,
  output logic [HISTORY-1:0]    train_ghr_o,
  output logic                  err_overflow_o,
`ifdef BRU_STATS_EN
  output logic [31:0]           stat_resolved_o,
  output logic [31:0]           stat_mispredict_o,
`endif
  output logic                  err_underflow_o
);

  localparam int CW = DEPTH_ADDR + 1;

  // Checkpoint storage. The entries carry no reset: the pointers and the count
  // define which entries are valid.
  logic [PC_WIDTH-1:0] pc_mem     [DEPTH];
  logic                pred_mem   [DEPTH];
  logic [PC_WIDTH-1:0] target_mem [DEPTH];
  logic [HISTORY-1:0]  ghr_mem    [DEPTH];

  logic [DEPTH_ADDR-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_ADDR-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q,  count_d;

  logic                  mispredict_q;
  logic [PC_WIDTH-1:0]   redirect_pc_q;
  logic [HISTORY-1:0]    restore_ghr_q;
  logic                  train_valid_q;
  logic [PC_WIDTH-1:0]   train_pc_q;
  logic                  train_taken_q;
  logic                  train_pred_q;
  logic [HISTORY-1:0]    train_ghr_q;
  logic                  err_overflow_q;
  logic                  err_underflow_q;

  logic                  full_w, empty_w;
  logic                  res_ok, push_ok, flush;
  logic                  dir_miss, tgt_miss, miss;
  logic [PC_WIDTH-1:0]   head_pc, head_target;
  logic                  head_pred;
  logic [HISTORY-1:0]    head_ghr;
  logic [PC_WIDTH-1:0]   redirect_d;
  logic [HISTORY-1:0]    restore_d;

  assign full_w  = (count_q == CW'(DEPTH));
  assign empty_w = (count_q == '0);

  assign head_pc     = pc_mem[rd_ptr_q];
  assign head_pred   = pred_mem[rd_ptr_q];
  assign head_target = target_mem[rd_ptr_q];
  assign head_ghr    = ghr_mem[rd_ptr_q];

  // A resolve on an empty FIFO never bypasses a push arriving in the same cycle.
  assign res_ok   = resolve_i & ~empty_w;
  assign dir_miss = head_pred != resolve_taken_i;
  assign tgt_miss = resolve_taken_i & head_pred & (head_target != resolve_target_i);
  assign miss     = dir_miss | tgt_miss;
  assign flush    = res_ok & miss;

  // A push during a flush is wrong-path, so it is dropped without raising an
  // error. When the FIFO is full, a push is accepted only if a pop happens in
  // the same cycle.
  assign push_ok = push_i & ~flush & (~full_w | res_ok);

  assign redirect_d = resolve_taken_i ? resolve_target_i : head_pc + PC_WIDTH'(4);
  assign restore_d  = {head_ghr[HISTORY-2:0], resolve_taken_i};

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      // Discard the head and every younger checkpoint in one step.
      rd_ptr_d = wr_ptr_q;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + DEPTH_ADDR'(1);
      if (res_ok)  rd_ptr_d = rd_ptr_q + DEPTH_ADDR'(1);
      case ({push_ok, res_ok})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      pc_mem[wr_ptr_q]     <= push_pc_i;
      pred_mem[wr_ptr_q]   <= push_pred_i;
      target_mem[wr_ptr_q] <= push_target_i;
      ghr_mem[wr_ptr_q]    <= push_ghr_i;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      count_q         <= '0;
      mispredict_q    <= 1'b0;
      redirect_pc_q   <= '0;
      restore_ghr_q   <= '0;
      train_valid_q   <= 1'b0;
      train_pc_q      <= '0;
      train_taken_q   <= 1'b0;
      train_pred_q    <= 1'b0;
      train_ghr_q     <= '0;
      err_overflow_q  <= 1'b0;
      err_underflow_q <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      mispredict_q  <= flush;
      train_valid_q <= res_ok;
      // The payload registers hold their value between resolves. They are
      // meaningful only while the matching strobe is high.
      if (res_ok) begin
        redirect_pc_q <= redirect_d;
        restore_ghr_q <= restore_d;
        train_pc_q    <= head_pc;
        train_taken_q <= resolve_taken_i;
        train_pred_q  <= head_pred;
        train_ghr_q   <= head_ghr;
      end
      if (push_i & full_w & ~res_ok) err_overflow_q  <= 1'b1;
      if (resolve_i & empty_w)       err_underflow_q <= 1'b1;
    end
  end

`ifdef BRU_STATS_EN
  logic [31:0] stat_resolved_q, stat_mispredict_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      stat_resolved_q   <= '0;
      stat_mispredict_q <= '0;
    end else begin
      if (res_ok && stat_resolved_q != 32'hFFFF_FFFF)
        stat_resolved_q <= stat_resolved_q + 32'd1;
      if (flush && stat_mispredict_q != 32'hFFFF_FFFF)
        stat_mispredict_q <= stat_mispredict_q + 32'd1;
    end
  end

  assign stat_resolved_o   = stat_resolved_q;
  assign stat_mispredict_o = stat_mispredict_q;
`endif

  assign full_o          = full_w;
  assign empty_o         = empty_w;
  assign count_o         = count_q;
  assign mispredict_o    = mispredict_q;
  assign redirect_pc_o   = redirect_pc_q;
  assign restore_ghr_o   = restore_ghr_q;
  assign train_valid_o   = train_valid_q;
  assign train_pc_o      = train_pc_q;
  assign train_taken_o   = train_taken_q;
  assign train_pred_o    = train_pred_q;
  assign train_ghr_o     = train_ghr_q;
  assign err_overflow_o  = err_overflow_q;
  assign err_underflow_o = err_underflow_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Testbench for branch_resolve_unit (DEPTH=4, PC_WIDTH=32, HISTORY=16).
// Each vector drives one cycle of inputs. The outputs are then compared #1
// after the rising edge.
module tb_branch_resolve_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        push, push_pred, resolve, resolve_taken;
  logic [31:0] push_pc, push_target, resolve_target;
  logic [15:0] push_ghr;
  logic        full, empty, mispredict, train_valid, train_taken, train_pred;
  logic [2:0]  count;
  logic [31:0] redirect_pc, train_pc;
  logic [15:0] restore_ghr, train_ghr;
  logic        err_overflow, err_underflow;
`ifdef BRU_STATS_EN
  logic [31:0] stat_resolved, stat_mispredict;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  branch_resolve_unit #(.PC_WIDTH(32), .HISTORY(16), .DEPTH(4)) dut (
    .clk_i            (clk),
    .reset_i          (reset),
    .push_i           (push),
    .push_pc_i        (push_pc),
    .push_pred_i      (push_pred),
    .push_target_i    (push_target),
    .push_ghr_i       (push_ghr),
    .resolve_i        (resolve),
    .resolve_taken_i  (resolve_taken),
    .resolve_target_i (resolve_target),
    .full_o           (full),
    .empty_o          (empty),
    .count_o          (count),
    .mispredict_o     (mispredict),
    .redirect_pc_o    (redirect_pc),
    .restore_ghr_o    (restore_ghr),
    .train_valid_o    (train_valid),
    .train_pc_o       (train_pc),
    .train_taken_o    (train_taken),
    .train_pred_o     (train_pred),
    .train_ghr_o      (train_ghr),
    .err_overflow_o   (err_overflow),
`ifdef BRU_STATS_EN
    .stat_resolved_o  (stat_resolved),
    .stat_mispredict_o(stat_mispredict),
`endif
    .err_underflow_o  (err_underflow)
  );

  typedef struct {
    int push; int pc; int pred; int tgt; int ghr;
    int res;  int rtk; int rtgt;
    int cnt;  int full; int tv; int mp; int rpc; int rghr;
    int tpc;  int tpred; int ttk; int tghr; int ovf; int unf;
  } vec_t;

  vec_t vecs [21];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp, input int idx);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s vec=%0d actual=0x%0h required=0x%0h", name, idx, act, exp);
    end
  endtask

  task automatic idle_inputs();
    push = 0; push_pc = 0; push_pred = 0; push_target = 0; push_ghr = 0;
    resolve = 0; resolve_taken = 0; resolve_target = 0;
  endtask

  task automatic check_all_zero(input string tag, input int idx);
    chk({tag, "_count"},  32'(count), 0, idx);
    chk({tag, "_empty"},  32'(empty), 1, idx);
    chk({tag, "_full"},   32'(full), 0, idx);
    chk({tag, "_tv"},     32'(train_valid), 0, idx);
    chk({tag, "_mp"},     32'(mispredict), 0, idx);
    chk({tag, "_rpc"},    redirect_pc, 0, idx);
    chk({tag, "_rghr"},   32'(restore_ghr), 0, idx);
    chk({tag, "_tpc"},    train_pc, 0, idx);
    chk({tag, "_tghr"},   32'(train_ghr), 0, idx);
    chk({tag, "_tpred"},  32'(train_pred), 0, idx);
    chk({tag, "_ttaken"}, 32'(train_taken), 0, idx);
    chk({tag, "_ovf"},    32'(err_overflow), 0, idx);
    chk({tag, "_unf"},    32'(err_underflow), 0, idx);
`ifdef BRU_STATS_EN
    chk({tag, "_stat_res"}, stat_resolved, 0, idx);
    chk({tag, "_stat_mp"},  stat_mispredict, 0, idx);
`endif
  endtask

  initial begin
    //          push pc        pred tgt        ghr       res rtk rtgt       cnt full tv mp rpc        rghr      tpc        tpr ttk tghr      ovf unf
    vecs[0]  = '{1, 32'h100,  1, 32'h200,  16'h00AA, 0, 0, 0,          1, 0, 0, 0, 0,         0,        0,         0, 0, 0,         0, 0};
    vecs[1]  = '{0, 0,        0, 0,        0,        1, 1, 32'h200,    0, 0, 1, 0, 0,         0,        32'h100,   1, 1, 16'h00AA,  0, 0};
    vecs[2]  = '{1, 32'h40,   1, 32'h500,  16'h8001, 0, 0, 0,          1, 0, 0, 0, 0,         0,        0,         0, 0, 0,         0, 0};
    vecs[3]  = '{0, 0,        0, 0,        0,        1, 0, 0,          0, 0, 1, 1, 32'h44,    16'h0002, 32'h40,    1, 0, 16'h8001,  0, 0};
    vecs[4]  = '{1, 32'h80,   1, 32'h300,  16'h1234, 0, 0, 0,          1, 0, 0, 0, 0,         0,        0,         0, 0, 0,         0, 0};
    vecs[5]  = '{0, 0,        0, 0,        0,        1, 1, 32'h304,    0, 0, 1, 1, 32'h304,   16'h2469, 32'h80,    1, 1, 16'h1234,  0, 0};
    vecs[6]  = '{1, 32'h1000, 0, 0,        16'h0001, 0, 0, 0,          1, 0, 0, 0, 0,         0,        0,         0, 0, 0,         0, 0};
    vecs[7]  = '{1, 32'h1004, 1, 32'h2000, 16'h0002, 0, 0, 0,          2, 0, 0, 0, 0,         0,        0,         0, 0, 0,         0, 0};
    vecs[8]  = '{1, 32'h1008, 0, 0,        16'h0005, 0, 0, 0,          3, 0, 0, 0, 0,         0,        0,         0, 0, 0,         0, 0};
    vecs[9]  = '{1, 32'h100C, 1, 0,        0,        1, 1, 32'h3000,   0, 0, 1, 1, 32'h3000,  16'h0003, 32'h1000,  0, 1, 16'h0001,  0, 0};
    vecs[10] = '{0, 0,        0, 0,        0,        1, 0, 0,          0, 0, 0, 0, 0,         0,        0,         0, 0, 0,         0, 1};
    vecs[11] = '{1, 32'h2000, 0, 0,        16'h0010, 0, 0, 0,          1, 0, 0, 0, 0,         0,        0,         0, 0, 0,         0, 1};
    vecs[12] = '{1, 32'h2004, 0, 0,        16'h0011, 0, 0, 0,          2, 0, 0, 0, 0,         0,        0,         0, 0, 0,         0, 1};
    vecs[13] = '{1, 32'h2008, 0, 0,        16'h0012, 0, 0, 0,          3, 0, 0, 0, 0,         0,        0,         0, 0, 0,         0, 1};
    vecs[14] = '{1, 32'h200C, 0, 0,        16'h0013, 0, 0, 0,          4, 1, 0, 0, 0,         0,        0,         0, 0, 0,         0, 1};
    vecs[15] = '{1, 32'h2010, 0, 0,        16'h0014, 0, 0, 0,          4, 1, 0, 0, 0,         0,        0,         0, 0, 0,         1, 1};
    vecs[16] = '{1, 32'h2014, 0, 0,        16'h0015, 1, 0, 0,          4, 1, 1, 0, 0,         0,        32'h2000,  0, 0, 16'h0010,  1, 1};
    vecs[17] = '{0, 0,        0, 0,        0,        1, 0, 0,          3, 0, 1, 0, 0,         0,        32'h2004,  0, 0, 16'h0011,  1, 1};
    vecs[18] = '{0, 0,        0, 0,        0,        1, 0, 0,          2, 0, 1, 0, 0,         0,        32'h2008,  0, 0, 16'h0012,  1, 1};
    vecs[19] = '{0, 0,        0, 0,        0,        1, 0, 0,          1, 0, 1, 0, 0,         0,        32'h200C,  0, 0, 16'h0013,  1, 1};
    vecs[20] = '{0, 0,        0, 0,        0,        1, 0, 0,          0, 0, 1, 0, 0,         0,        32'h2014,  0, 0, 16'h0015,  1, 1};

    idle_inputs();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_all_zero("reset", -1);

    for (int i = 0; i < 21; i++) begin
      @(negedge clk);
      push           = 1'(vecs[i].push);
      push_pc        = 32'(vecs[i].pc);
      push_pred      = 1'(vecs[i].pred);
      push_target    = 32'(vecs[i].tgt);
      push_ghr       = 16'(vecs[i].ghr);
      resolve        = 1'(vecs[i].res);
      resolve_taken  = 1'(vecs[i].rtk);
      resolve_target = 32'(vecs[i].rtgt);
      @(posedge clk);
      #1;
      chk("count", 32'(count), 32'(vecs[i].cnt), i);
      chk("empty", 32'(empty), (vecs[i].cnt == 0) ? 32'd1 : 32'd0, i);
      chk("full",  32'(full), 32'(vecs[i].full), i);
      chk("train_valid", 32'(train_valid), 32'(vecs[i].tv), i);
      chk("mispredict",  32'(mispredict), 32'(vecs[i].mp), i);
      chk("err_overflow",  32'(err_overflow), 32'(vecs[i].ovf), i);
      chk("err_underflow", 32'(err_underflow), 32'(vecs[i].unf), i);
      if (vecs[i].tv != 0) begin
        chk("train_pc",    train_pc, 32'(vecs[i].tpc), i);
        chk("train_pred",  32'(train_pred), 32'(vecs[i].tpred), i);
        chk("train_taken", 32'(train_taken), 32'(vecs[i].ttk), i);
        chk("train_ghr",   32'(train_ghr), 32'(vecs[i].tghr), i);
      end
      if (vecs[i].mp != 0) begin
        chk("redirect_pc", redirect_pc, 32'(vecs[i].rpc), i);
        chk("restore_ghr", 32'(restore_ghr), 32'(vecs[i].rghr), i);
      end
      $display("vec %0d: push=%0d res=%0d count=%0d tv=%0d mp=%0d tpc=0x%0h rpc=0x%0h",
               i, vecs[i].push, vecs[i].res, count, train_valid, mispredict, train_pc, redirect_pc);
    end

    // Asynchronous reset: one resolve completes, a second push sits in the
    // FIFO and a resolve for it is pending. Reset is asserted between edges.
    @(negedge clk);
    idle_inputs();
    push = 1; push_pc = 32'h3000; push_pred = 1; push_target = 32'h3100; push_ghr = 16'h0F0F;
    @(negedge clk);
    idle_inputs();
    push = 1; push_pc = 32'h3004; push_pred = 0; push_ghr = 16'h00F0;
    resolve = 1; resolve_taken = 0;   // head predicted taken -> mispredict
    @(posedge clk);
    #1;
    chk("pre_reset_mp", 32'(mispredict), 1, 100);
    @(negedge clk);
    idle_inputs();
    push = 1; push_pc = 32'h3008; push_pred = 1; push_target = 32'h3200;
    @(posedge clk);
    #1;
    chk("pre_reset_count", 32'(count), 1, 101);
    @(negedge clk);
    idle_inputs();
    resolve = 1; resolve_taken = 1; resolve_target = 32'h3200;
    #2;
    reset = 1'b1;
    #1;
    check_all_zero("async_reset", 102);
    @(posedge clk);
    @(negedge clk);
    idle_inputs();
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      check_all_zero("post_reset", 103 + c);
      $display("post-reset cycle %0d: tv=%0d mp=%0d count=%0d", c, train_valid, mispredict, count);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Safety net so that a stuck run always terminates.
  initial begin
    #100000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
